acondicionador_botones: RTL and testbench
=========================================

Name: acondicionador_botones

Overview:
Conditions the raw board pushbuttons that drive the minesweeper game: the four movement buttons, select cell, mark flag and start.
Per button it synchronises, debounces, detects presses and optionally auto-repeats.
A fair single-winner arbiter then emits at most one one-cycle command pulse per clock. These pulses are what the game FSM and the movement logic consume.
It runs in the game clock domain, so every pulse lasts exactly one game clock.

Parameters:
N_BTN, 7, number of buttons; bit order: 0 arriba, 1 derecha, 2 izquierda, 3 abajo, 4 seleccionar, 5 bandera, 6 iniciar.
ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (board KEYs).
DEBOUNCE_CYCLES (D), 4, consecutive stable samples required to accept a press or release; legal range ≥2.
REPEAT_DELAY, 20, cycles from the first event to the first auto-repeat event.
REPEAT_RATE, 8, cycles between subsequent auto-repeat events.
REPEAT_MASK, 7'b0001111, per-button auto-repeat enable (movement buttons only).

Ports:
clk  in  1  game clock, rising edge.
rst  in  1  asynchronous reset, active-low.
btn_raw  in  N_BTN  raw asynchronous button levels.
clear  in  1  synchronous; drops all pending and not-yet-issued events.
pulse_out  out  N_BTN  one-hot or zero command pulse, registered.
level_out  out  N_BTN  debounced "held" level per button, registered.

Behaviour:
- Reset values (rst low, asynchronous): sync flops 0 (inactive after polarity), all FSMs IDLE, counters 0, pending 0, pulse_out 0, level_out 0.
- Polarity and synchronisation:
  - Polarity is applied first: s_in = btn_raw ^ {N_BTN{ACTIVE_LOW}}.
  - Two-flop synchroniser per bit; the FSM sees sync2.
- Counters: one per button, width clog2(max(D, REPEAT_DELAY, REPEAT_RATE)+1), saturating.
- Per-button FSM:
  - IDLE: sync2=1 → DB_PRESS, cnt=1.
  - DB_PRESS:
    - sync2=0 → IDLE (bounce rejected, no event).
    - sync2=1 and cnt==D → PRESSED, raise event, cnt=1.
    - Otherwise cnt++.
  - PRESSED:
    - sync2=0 → DB_REL, cnt=1.
    - Else if REPEAT_MASK[i] and cnt==REPEAT_DELAY → REPEAT, raise event, cnt=1.
    - Else cnt++.
  - REPEAT:
    - sync2=0 → DB_REL, cnt=1.
    - Else if cnt==REPEAT_RATE → raise event, cnt=1.
    - Else cnt++.
  - DB_REL:
    - sync2=1 → PRESSED, cnt=1, no event; repeat timing restarts.
    - sync2=0 and cnt==D → IDLE.
    - Otherwise cnt++.
    - No events are raised in DB_REL.
- level_out[i]: 1 exactly when the registered state is PRESSED, REPEAT or DB_REL.
- Arbiter, evaluated each edge:
  - req = pending | new_events.
  - pulse_out <= lowest-index set bit of req (one-hot), or 0 if req is 0.
  - pending <= req & ~grant.
- Latency: with no contention, pulse_out is high during the cycle after edge D+3. Edges are counted from the first edge that samples the new raw level as edge 1. The pulse lasts exactly one cycle.
- Simultaneous events:
  - Granted lowest index first; the others stay pending and issue on the following cycles, one per cycle, with no loss.
  - A repeat event on a bit already pending coalesces into a single pulse.
- clear=1:
  - pending <= 0 and pulse_out <= 0 on that edge.
  - new_events on that edge are discarded.
  - FSMs, counters and level_out are unaffected.
- Reset mid-operation: everything returns to reset values immediately. A button still held after rst deasserts is re-detected as a fresh press after the normal latency.
- Held button, auto-repeat disabled: exactly one pulse per press regardless of hold length.

Test Plan:
1. Single press, D=4: raw bit 4 goes active and is held 50 cycles → pulse_out=7'b0010000 for one cycle after edge 7; level_out[4] high from edge 7 until the release debounce completes.
2. Bounce rejection: raw bit 1 toggles active 3 cycles, inactive 1, active 2, then inactive → no pulse_out, level_out stays 0.
3. Auto-repeat on bit 0 held 60 cycles (REPEAT_DELAY 20, REPEAT_RATE 8) → pulses after edges 7, 27, 35, 43, 51, 59. The same hold on bit 5 (mask 0) → a single pulse after edge 7.
4. Simultaneous press of bits 3 and 0 on the same cycle → bit0 pulse after edge 7, bit3 pulse after edge 8, no drops.
5. Bits 2 and 6 pressed together, clear asserted on the edge their events are raised → no pulses; level_out[2] and level_out[6] still go high.
6. rst asserted low mid-REPEAT on bit 3 → outputs 0 asynchronously. With the button still held after release of rst → a pulse after edge 7 relative to the first post-reset edge.

Source files
------------

// File: rtl/acondicionador_botones_if.sv
// Button-conditioner bus: raw button levels and clear in, command pulses and held levels out.
// The master side belongs to the board/test logic, the slave side to the conditioner.
interface acondicionador_botones_if #(
  parameter int N_BTN = 7
);
  logic [N_BTN-1:0] btn_raw;
  logic             clear;
  logic [N_BTN-1:0] pulse_out;
  logic [N_BTN-1:0] level_out;

  modport master (
    output btn_raw,
    output clear,
    input  pulse_out,
    input  level_out
  );

  modport slave (
    input  btn_raw,
    input  clear,
    output pulse_out,
    output level_out
  );
endinterface

// File: rtl/acondicionador_botones.sv
// Minesweeper pushbutton conditioner: per-button sync, debounce, press detect and auto-repeat,
// followed by a lowest-index-first arbiter that emits at most one one-cycle command pulse per clock.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | button released and stable
// DB_PRESS | press seen, counting stable samples before accepting it
// PRESSED  | press accepted, waiting for the first auto-repeat
// REPEAT   | auto-repeating at the repeat rate
// DB_REL   | release seen, counting stable samples before accepting it
module acondicionador_botones #(
  parameter int               N_BTN           = 7,
  parameter bit               ACTIVE_LOW      = 1'b1,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               REPEAT_DELAY    = 20,
  parameter int               REPEAT_RATE     = 8,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 7'b0001111
) (
  input  logic                    clk,
  input  logic                    rst,
  acondicionador_botones_if.slave bus
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CNT);
  localparam logic [CW-1:0] CNT_DB  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_RD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] CNT_RR  = CW'(REPEAT_RATE);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    PRESSED  = 3'd2,
    REPEAT   = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  logic [N_BTN-1:0] s_in;
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];

  logic [N_BTN-1:0] event_v;
  logic [N_BTN-1:0] req;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] level_q, level_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign s_in = bus.btn_raw ^ {N_BTN{ACTIVE_LOW}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pending_q <= '0;
      pulse_q   <= '0;
      level_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= s_in;
      sync2_q   <= sync1_q;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      level_q   <= level_d;
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    event_v = '0;
    level_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = sat_inc(cnt_q[i]);
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = cnt_q[i];
          if (sync2_q[i]) begin
            state_d[i] = DB_PRESS;
            cnt_d[i]   = CNT_ONE;
          end
        end
        DB_PRESS: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = cnt_q[i];
          end else if (cnt_q[i] == CNT_DB) begin
            state_d[i] = PRESSED;
            event_v[i] = 1'b1;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = DB_REL;
            cnt_d[i]   = CNT_ONE;
          end else if (REPEAT_MASK[i] && cnt_q[i] == CNT_RD) begin
            state_d[i] = REPEAT;
            event_v[i] = 1'b1;
            cnt_d[i]   = CNT_ONE;
          end
        end
        REPEAT: begin
          if (!sync2_q[i]) begin
            state_d[i] = DB_REL;
            cnt_d[i]   = CNT_ONE;
          end else if (cnt_q[i] == CNT_RR) begin
            event_v[i] = 1'b1;
            cnt_d[i]   = CNT_ONE;
          end
        end
        DB_REL: begin
          // A re-press during release debounce restarts the repeat delay silently.
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = CNT_ONE;
          end else if (cnt_q[i] == CNT_DB) begin
            state_d[i] = IDLE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == REPEAT) || (state_d[i] == DB_REL);
    end
  end

  // Lowest set bit wins; losers stay pending, so a repeat on a pending bit merges into it.
  always_comb begin
    req       = pending_q | (bus.clear ? '0 : event_v);
    grant     = req & (~req + 1'b1);
    pulse_d   = bus.clear ? '0 : grant;
    pending_d = bus.clear ? '0 : (req & ~grant);
  end

  assign bus.pulse_out = pulse_q;
  assign bus.level_out = level_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones: expected pulses (cycle, value) are queued when
// a button is driven and popped whenever the DUT raises a pulse.
module tb_acondicionador_botones;

  logic clk;
  logic rst;
  int   edge_n;
  int   total;
  int   bad;
  int   base;
  logic [6:0] press_v;

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } exp_t;

  exp_t sb_q[$];

  acondicionador_botones_if #(.N_BTN(7)) bus ();

  acondicionador_botones dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic push(input int cyc, input logic [6:0] val);
    exp_t e;
    e.cyc = cyc;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic set_press(input logic [6:0] v);
    press_v     = v;
    bus.btn_raw = ~v;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.pulse_out != 7'd0) begin
      if (sb_q.size() == 0) begin
        chk("extra_pulse", int'(bus.pulse_out), 0);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_val", int'(bus.pulse_out), int'(e.val));
        chk("pulse_cyc", edge_n, e.cyc);
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.clear = 1'b0;
    set_press(7'h00);
    #23;
    chk("rst_pulse", int'(bus.pulse_out), 0);
    chk("rst_level", int'(bus.level_out), 0);
    @(negedge clk);
    rst = 1'b1;
    step(3);

    // single press on seleccionar, level follows press and release debounce
    base = edge_n;
    push(base + 7, 7'h10);
    set_press(7'h10);
    wait_to(base + 6);
    chk("lvl4_pre", int'(bus.level_out[4]), 0);
    wait_to(base + 7);
    chk("lvl4_on", int'(bus.level_out[4]), 1);
    wait_to(base + 50);
    base = edge_n;
    set_press(7'h00);
    wait_to(base + 6);
    chk("lvl4_hold", int'(bus.level_out[4]), 1);
    wait_to(base + 7);
    chk("lvl4_off", int'(bus.level_out[4]), 0);
    step(4);

    // bounce on derecha: 3 on, 1 off, 2 on, then off
    set_press(7'h02); step(3);
    set_press(7'h00); step(1);
    set_press(7'h02); step(2);
    set_press(7'h00);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("bounce_lvl1", int'(bus.level_out[1]), 0);
    end

    // auto-repeat on arriba
    base = edge_n;
    push(base + 7,  7'h01);
    push(base + 27, 7'h01);
    push(base + 35, 7'h01);
    push(base + 43, 7'h01);
    push(base + 51, 7'h01);
    push(base + 59, 7'h01);
    set_press(7'h01);
    wait_to(base + 60);
    set_press(7'h00);
    step(12);

    // same hold on bandera: no repeat
    base = edge_n;
    push(base + 7, 7'h20);
    set_press(7'h20);
    wait_to(base + 60);
    set_press(7'h00);
    step(12);

    // simultaneous abajo + arriba
    base = edge_n;
    push(base + 7, 7'h01);
    push(base + 8, 7'h08);
    set_press(7'h09);
    wait_to(base + 12);
    set_press(7'h00);
    step(12);

    // clear drops a pending loser
    base = edge_n;
    push(base + 7, 7'h02);
    set_press(7'h12);
    wait_to(base + 7);
    bus.clear = 1'b1;
    wait_to(base + 8);
    bus.clear = 1'b0;
    wait_to(base + 12);
    set_press(7'h00);
    step(12);

    // clear on the event edge drops both new events, levels unaffected
    base = edge_n;
    set_press(7'h44);
    wait_to(base + 6);
    bus.clear = 1'b1;
    wait_to(base + 7);
    bus.clear = 1'b0;
    chk("clr_pulse", int'(bus.pulse_out), 0);
    chk("clr_lvl2", int'(bus.level_out[2]), 1);
    chk("clr_lvl6", int'(bus.level_out[6]), 1);
    wait_to(base + 12);
    set_press(7'h00);
    step(12);

    // reset in the middle of repeat on abajo, button held through reset
    base = edge_n;
    push(base + 7, 7'h08);
    set_press(7'h08);
    wait_to(base + 26);
    @(posedge clk);
    #1;
    chk("rep_pulse3", int'(bus.pulse_out), 8);
    rst = 1'b0;
    #1;
    chk("arst_pulse", int'(bus.pulse_out), 0);
    chk("arst_level", int'(bus.level_out), 0);
    step(3);
    rst = 1'b1;
    base = edge_n;
    push(base + 7, 7'h08);
    wait_to(base + 6);
    chk("post_rst_lvl_pre", int'(bus.level_out[3]), 0);
    wait_to(base + 8);
    chk("post_rst_lvl", int'(bus.level_out[3]), 1);
    wait_to(base + 12);
    set_press(7'h00);
    step(12);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
